// File: rtl/light_phase_timer.sv
// light_phase_timer: measures the current traffic-light phase and issues expiry pulses.
//
// A prescaler divides clk into time units. A unit counter tracks elapsed units
// of the phase the controller is currently showing. When the phase reaches its
// configured length, the matching expiry pulse fires for one cycle:
// cou2 ends red, cou1 ends yellow, and cou4 ends green.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   en     - controller enable (low = controller idle)
//   r,y,g  - lamp outputs of the controller
//   cou1   - yellow-expired pulse (registered)
//   cou2   - red-expired pulse (registered)
//   cou4   - green-expired pulse (registered)
//   remain - units left in the current phase (registered)
//   fault  - sticky illegal-lamp flag (registered)
module light_phase_timer #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned RED_UNITS = 2,
    parameter int unsigned YEL_UNITS = 1,
    parameter int unsigned GRN_UNITS = 4,
    parameter int unsigned UW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          r,
    input  logic          y,
    input  logic          g,
    output logic          cou1,
    output logic          cou2,
    output logic          cou4,
    output logic [UW-1:0] remain,
    output logic          fault
);

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_RED,
        PH_YEL,
        PH_GRN
    } phase_e;

    state_e          state_q, state_d;
    phase_e          last_q, last_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [UW-1:0]   units_q, units_d;
    logic [UW-1:0]   remain_q, remain_d;
    logic [2:0]      cou_q, cou_d;      // {cou4, cou2, cou1}
    logic            fault_q, fault_d;

    phase_e          phase_c;
    logic            legal_c;
    logic [UW-1:0]   target_c;
    logic [2:0]      pulse_c;
    logic [UW-1:0]   units_inc_c;

    // Lamp decode: exactly one lamp lit with en high is a legal phase.
    always_comb begin
        phase_c  = PH_NONE;
        target_c = '0;
        pulse_c  = 3'b000;
        case ({r, y, g})
            3'b100:  phase_c = PH_RED;
            3'b010:  phase_c = PH_YEL;
            3'b001:  phase_c = PH_GRN;
            default: phase_c = PH_NONE;
        endcase
        legal_c = en && (phase_c != PH_NONE);
        case (phase_c)
            PH_RED: begin
                target_c = UW'(RED_UNITS);
                pulse_c  = 3'b010;
            end
            PH_YEL: begin
                target_c = UW'(YEL_UNITS);
                pulse_c  = 3'b001;
            end
            PH_GRN: begin
                target_c = UW'(GRN_UNITS);
                pulse_c  = 3'b100;
            end
            default: begin
                target_c = '0;
                pulse_c  = 3'b000;
            end
        endcase
        units_inc_c = units_q + UW'(1);
    end

    // Next-state: idle/illegal clears everything, a new phase reloads, RUN counts.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        presc_d  = presc_q;
        units_d  = units_q;
        remain_d = remain_q;
        fault_d  = fault_q;
        cou_d    = 3'b000;

        if (!legal_c) begin
            state_d  = ST_IDLE;
            last_d   = PH_NONE;
            presc_d  = '0;
            units_d  = '0;
            remain_d = '0;
            if (en) begin
                fault_d = 1'b1;
            end
        end else if (phase_c != last_q) begin
            // Phase change wins over any expiry due this cycle.
            state_d  = ST_RUN;
            last_d   = phase_c;
            presc_d  = '0;
            units_d  = '0;
            remain_d = target_c;
        end else if (state_q == ST_RUN) begin
            if (presc_q == TICK_LAST) begin
                presc_d  = '0;
                units_d  = units_inc_c;
                remain_d = (remain_q != '0) ? remain_q - UW'(1) : '0;
                if (units_inc_c == target_c) begin
                    state_d = ST_DONE;
                    cou_d   = pulse_c;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= PH_NONE;
            presc_q  <= '0;
            units_q  <= '0;
            remain_q <= '0;
            cou_q    <= 3'b000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            presc_q  <= presc_d;
            units_q  <= units_d;
            remain_q <= remain_d;
            cou_q    <= cou_d;
            fault_q  <= fault_d;
        end
    end

    assign cou1   = cou_q[0];
    assign cou2   = cou_q[1];
    assign cou4   = cou_q[2];
    assign remain = remain_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Self-checking bench for light_phase_timer with default parameters.
module tb_light_phase_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       r;
    logic       y;
    logic       g;
    logic       cou1;
    logic       cou2;
    logic       cou4;
    logic [3:0] remain;
    logic       fault;

    typedef struct {
        int         cyc;
        logic [2:0] cou;   // {cou4, cou2, cou1}
        logic [3:0] rem;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    light_phase_timer dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .r      (r),
        .y      (y),
        .g      (g),
        .cou1   (cou1),
        .cou2   (cou2),
        .cou4   (cou4),
        .remain (remain),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_idle(input int n);
        en = 1'b0;
        {r, y, g} = 3'b000;
        repeat (n) tick();
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        {r, y, g} = 3'b100;
        tick();
        tick();
        checks++;
        if ({cou4, cou2, cou1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cou got=%b exp=000", {cou4, cou2, cou1});
        end
        checks++;
        if (remain !== 4'd0) begin
            errors++;
            $display("FAIL reset_remain got=%0d exp=0", remain);
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault got=%b exp=0", fault);
        end
        reset = 1'b0;
        go_idle(2);
    endtask

    task automatic test_default_red();
        exp_t       e;
        logic [2:0] exp_cou;
        go_idle(2);
        en = 1'b1;
        {r, y, g} = 3'b100;
        cyc = -1;
        sb.push_back('{0, 3'b000, 4'd2});
        sb.push_back('{4, 3'b000, 4'd1});
        sb.push_back('{8, 3'b010, 4'd0});
        sb.push_back('{15, 3'b000, 4'd0});
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cou = 3'b000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_cou = e.cou;
                checks++;
                if (remain !== e.rem) begin
                    errors++;
                    $display("FAIL red_remain cyc=%0d got=%0d exp=%0d", cyc, remain, e.rem);
                end
            end
            checks++;
            if ({cou4, cou2, cou1} !== exp_cou) begin
                errors++;
                $display("FAIL red_cou cyc=%0d got=%b exp=%b", cyc, {cou4, cou2, cou1}, exp_cou);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL red_leftover got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_closed_loop();
        exp_t       e;
        logic [2:0] exp_cou;
        logic [2:0] seq [5];
        logic [3:0] units [5];
        logic [2:0] pls [5];
        int         idx;
        int         next_change;
        seq   = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
        units = '{4'd2, 4'd1, 4'd4, 4'd1, 4'd2};
        pls   = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
        go_idle(2);
        idx = 0;
        en = 1'b1;
        {r, y, g} = seq[0];
        cyc = -1;
        sb.push_back('{0, 3'b000, units[0]});
        sb.push_back('{8, pls[0], 4'd0});
        next_change = 8;
        for (int i = 0; i < 52; i++) begin
            tick();
            exp_cou = 3'b000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_cou = e.cou;
                checks++;
                if (remain !== e.rem) begin
                    errors++;
                    $display("FAIL loop_remain cyc=%0d got=%0d exp=%0d", cyc, remain, e.rem);
                end
            end
            checks++;
            if ({cou4, cou2, cou1} !== exp_cou) begin
                errors++;
                $display("FAIL loop_cou cyc=%0d got=%b exp=%b", cyc, {cou4, cou2, cou1}, exp_cou);
            end
            // Controller advances to the next lamp on the expiry pulse.
            if (cyc == next_change && idx < 4) begin
                idx++;
                {r, y, g} = seq[idx];
                sb.push_back('{cyc + 1, 3'b000, units[idx]});
                sb.push_back('{cyc + 1 + 4 * int'(units[idx]), pls[idx], 4'd0});
                next_change = cyc + 1 + 4 * int'(units[idx]);
            end
        end
        checks++;
        if (sb.size() != 0 || idx != 4) begin
            errors++;
            $display("FAIL loop_leftover got=%0d/%0d exp=0/4", sb.size(), idx);
        end
    endtask

    task automatic test_hold_yellow();
        exp_t       e;
        logic [2:0] exp_cou;
        go_idle(2);
        en = 1'b1;
        {r, y, g} = 3'b010;
        cyc = -1;
        sb.push_back('{0, 3'b000, 4'd1});
        sb.push_back('{4, 3'b001, 4'd0});
        sb.push_back('{10, 3'b000, 4'd0});
        sb.push_back('{20, 3'b000, 4'd0});
        for (int i = 0; i < 22; i++) begin
            tick();
            exp_cou = 3'b000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_cou = e.cou;
                checks++;
                if (remain !== e.rem) begin
                    errors++;
                    $display("FAIL hold_remain cyc=%0d got=%0d exp=%0d", cyc, remain, e.rem);
                end
            end
            checks++;
            if ({cou4, cou2, cou1} !== exp_cou) begin
                errors++;
                $display("FAIL hold_cou cyc=%0d got=%b exp=%b", cyc, {cou4, cou2, cou1}, exp_cou);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL hold_leftover got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_en_drop();
        exp_t       e;
        logic [2:0] exp_cou;
        go_idle(2);
        en = 1'b1;
        {r, y, g} = 3'b100;
        cyc = -1;
        sb.push_back('{0, 3'b000, 4'd2});
        sb.push_back('{4, 3'b000, 4'd1});
        sb.push_back('{6, 3'b000, 4'd0});
        sb.push_back('{10, 3'b000, 4'd2});
        sb.push_back('{14, 3'b000, 4'd1});
        sb.push_back('{18, 3'b010, 4'd0});
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_cou = 3'b000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_cou = e.cou;
                checks++;
                if (remain !== e.rem) begin
                    errors++;
                    $display("FAIL endrop_remain cyc=%0d got=%0d exp=%0d", cyc, remain, e.rem);
                end
            end
            checks++;
            if ({cou4, cou2, cou1} !== exp_cou) begin
                errors++;
                $display("FAIL endrop_cou cyc=%0d got=%b exp=%b", cyc, {cou4, cou2, cou1}, exp_cou);
            end
            if (cyc == 5) en = 1'b0;
            if (cyc == 9) en = 1'b1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL endrop_leftover got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_fault();
        go_idle(2);
        en = 1'b1;
        {r, y, g} = 3'b101;
        tick();
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set got=%b exp=1", fault);
        end
        checks++;
        if ({cou4, cou2, cou1} !== 3'b000 || remain !== 4'd0) begin
            errors++;
            $display("FAIL fault_idle got=%b/%0d exp=000/0", {cou4, cou2, cou1}, remain);
        end
        {r, y, g} = 3'b100;
        tick();
        checks++;
        if (remain !== 4'd2) begin
            errors++;
            $display("FAIL fault_reload got=%0d exp=2", remain);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_sticky i=%0d got=%b exp=1", i, fault);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (fault !== 1'b0 || remain !== 4'd0) begin
            errors++;
            $display("FAIL fault_clear got=%b/%0d exp=0/0", fault, remain);
        end
    endtask

    task automatic test_reset_mid_green();
        exp_t       e;
        logic [2:0] exp_cou;
        go_idle(2);
        en = 1'b1;
        {r, y, g} = 3'b001;
        cyc = -1;
        sb.push_back('{0, 3'b000, 4'd4});
        sb.push_back('{4, 3'b000, 4'd3});
        sb.push_back('{5, 3'b000, 4'd0});
        sb.push_back('{6, 3'b000, 4'd4});
        sb.push_back('{10, 3'b000, 4'd3});
        sb.push_back('{22, 3'b100, 4'd0});
        for (int i = 0; i < 26; i++) begin
            tick();
            exp_cou = 3'b000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_cou = e.cou;
                checks++;
                if (remain !== e.rem) begin
                    errors++;
                    $display("FAIL grnrst_remain cyc=%0d got=%0d exp=%0d", cyc, remain, e.rem);
                end
            end
            checks++;
            if ({cou4, cou2, cou1} !== exp_cou || fault !== 1'b0) begin
                errors++;
                $display("FAIL grnrst_cou cyc=%0d got=%b/%b exp=%b/0", cyc, {cou4, cou2, cou1}, fault, exp_cou);
            end
            if (cyc == 4) reset = 1'b1;
            if (cyc == 5) reset = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL grnrst_leftover got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        {r, y, g} = 3'b000;
        cyc = 0;
        test_reset();
        test_default_red();
        test_closed_loop();
        test_hold_yellow();
        test_en_drop();
        test_fault();
        test_reset_mid_green();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_phase_timer.md
Name: light_phase_timer

Overview:
- Timing stage directly upstream of the traffic-light controller FSM.
- Watches the controller's enable and lamp outputs (r, y, g) and measures how long the current phase has lasted, using a clock prescaler and a unit counter.
- Issues the single-cycle expiry pulses the controller consumes: cou2 ends red, cou1 ends yellow, cou4 ends green.
- Also exports the remaining units of the current phase for display, and a sticky fault flag for illegal lamp combinations.

Parameters:
- TICK_DIV, 4, clocks per time unit; legal range 1..65535.
- RED_UNITS, 2, red phase length in units; drives cou2.
- YEL_UNITS, 1, yellow phase length in units; drives cou1.
- GRN_UNITS, 4, green phase length in units; drives cou4.
- UW, 4, width of the unit counter and of remain; every *_UNITS value must be 1..2^UW-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  controller enable; low means the controller is idle.
- r  input  1  red lamp from the controller.
- y  input  1  yellow lamp from the controller.
- g  input  1  green lamp from the controller.
- cou1  output  1  yellow-expired pulse, registered.
- cou2  output  1  red-expired pulse, registered.
- cou4  output  1  green-expired pulse, registered.
- remain  output  UW  units left in the current phase, registered.
- fault  output  1  sticky illegal-lamp flag, registered.

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE; prescaler=0; units=0; last_phase=none; cou1=cou2=cou4=0; remain=0; fault=0. Reset overrides every other input.
- Phase decode: exactly one of r/y/g high with en=1 gives a legal phase RED, YEL or GRN. Any other combination while en=1 is illegal.
- States:
  - IDLE: entered when en=0 or the phase is illegal. Prescaler and units held at 0, remain=0, no pulses.
  - RUN: counting the current phase.
  - DONE: the expiry pulse has been issued; counters frozen; waiting for a phase change.
- Load cycle: any cycle where the decoded legal phase differs from last_phase, including IDLE->legal. On that cycle:
  - prescaler=0, units=0;
  - remain=*_UNITS of the new phase;
  - last_phase=new phase;
  - state=RUN;
  - no pulse is issued.
- RUN, each cycle:
  - prescaler increments.
  - When prescaler==TICK_DIV-1 it wraps to 0 (a tick), units increments and remain decrements.
  - On the tick that makes units equal the phase's *_UNITS, the matching cou output goes high on the next cycle for exactly one cycle, and state goes to DONE.
- Latency: if the load cycle is cycle 0, the pulse is high in cycle *_UNITS*TICK_DIV. With defaults: red -> cou2 at cycle 8, yellow -> cou1 at cycle 4, green -> cou4 at cycle 16.
- DONE: all cou outputs are 0 from the cycle after the pulse. A phase held past expiry never re-pulses.
- Pulse exclusivity: at most one of cou1/cou2/cou4 is high in any cycle.
- Phase change takes priority over expiry: if a new legal phase is seen on the cycle expiry would be scheduled, perform a load and issue no pulse.
- en falling mid-phase: next state IDLE, counters cleared, any pending pulse cancelled, last_phase=none. The next legal phase is a fresh load.
- Illegal combination while en=1: fault=1 (sticky until reset), state IDLE, no pulses.
- Width rules: units and remain are unsigned UW bits. remain never underflows and reads 0 when a pulse fires. The prescaler is wide enough for TICK_DIV-1 (16 bits).
- TICK_DIV=1: a tick occurs every RUN cycle, so a phase expires after *_UNITS cycles.

Test Plan:
- Defaults. Reset 2 cycles, then en=1, r=1 held -> cou2 high only at cycle 8 after the load; remain steps 2,1,0 at cycles 4 and 8; cou1 and cou4 stay 0.
- Full cycle with the controller closed-loop: red, yellow, green, yellow, red -> pulses cou2@8, cou1@+4 (after the yellow load), cou4@+16, cou1@+4; exactly one pulse per phase; no double transitions.
- Hold y=1 for 20 cycles after the load -> cou1 pulses once at cycle 4, then stays 0; remain stays 0.
- Drop en to 0 at cycle 6 of red, restore en with r=1 at cycle 10 -> no cou2 at cycle 8; the new load is at cycle 10 and cou2 fires at cycle 18.
- Drive r=1 and g=1 together with en=1 -> fault=1 next cycle and stays 1 after legal inputs return; reset clears fault to 0.
- Assert reset=1 at cycle 5 of a green phase -> all outputs 0 next cycle; no cou4 afterwards until a fresh load plus 16 cycles.
